writeback_unit: RTL and testbench

- MEM/WB pipeline register plus writeback controller; the write-side driver of register_file.
- Registers the MEM-stage result and selects the writeback source (ALU, load data, PC+4 for jal).
- Drives write_reg/write_data/reg_write into register_file and supplies same-cycle forwarding data to the decode-side read ports.
- Keeps a per-register pending-write scoreboard that decode uses for RAW hazard stalls.

---
 rtl/writeback_unit_pkg.sv | 13 +
 rtl/writeback_unit_scoreboard.sv | 52 +++++
 rtl/writeback_unit.sv | 81 ++++++++
 tb/tb_writeback_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths, writeback-source encodings and the $zero index
package writeback_unit_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int SB_CNT_WIDTH = 2;
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_RSVD = 2'd3
    } wb_sel_e;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;
endpackage

// File: rtl/writeback_unit_scoreboard.sv
// pending_write_scoreboard: per-register in-flight write counters, sticky overflow and busy lookup
module pending_write_scoreboard
    import writeback_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = writeback_unit_pkg::REG_ADDR_WIDTH,
    parameter int SB_CNT_WIDTH   = writeback_unit_pkg::SB_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inc,
    input  logic [REG_ADDR_WIDTH-1:0] inc_reg,
    input  logic                      dec,
    input  logic [REG_ADDR_WIDTH-1:0] dec_reg,
    input  logic [REG_ADDR_WIDTH-1:0] read_reg_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_reg_2,
    input  logic                      fwd_hit_1,
    input  logic                      fwd_hit_2,
    output logic                      busy_1,
    output logic                      busy_2,
    output logic                      sb_overflow
);
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam logic [SB_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_WIDTH-1:0] CNT_ONE = SB_CNT_WIDTH'(1);
    logic [SB_CNT_WIDTH-1:0] cnt [NUM_REGS];
    logic [SB_CNT_WIDTH-1:0] cnt_1, cnt_2;
    assign cnt[0] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        logic up, dn;
        assign up = inc && (inc_reg == REG_ADDR_WIDTH'(g));
        assign dn = dec && (dec_reg == REG_ADDR_WIDTH'(g));
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                cnt[g] <= '0;
            else if (up && !dn && cnt[g] != CNT_MAX)
                cnt[g] <= cnt[g] + CNT_ONE;
            else if (dn && !up && cnt[g] != '0)
                cnt[g] <= cnt[g] - CNT_ONE;
        end
    end
    // a saturated issue only counts as overflow if no retire to the same register offsets it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sb_overflow <= 1'b0;
        else if (inc && cnt[inc_reg] == CNT_MAX && !(dec && dec_reg == inc_reg))
            sb_overflow <= 1'b1;
    end
    assign cnt_1 = cnt[read_reg_1];
    assign cnt_2 = cnt[read_reg_2];
    assign busy_1 = (cnt_1 != '0) && !(cnt_1 == CNT_ONE && fwd_hit_1);
    assign busy_2 = (cnt_2 != '0) && !(cnt_2 == CNT_ONE && fwd_hit_2);
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB register, writeback source mux, same-cycle forwarding and pending-write scoreboard
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = writeback_unit_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = writeback_unit_pkg::REG_ADDR_WIDTH,
    parameter int SB_CNT_WIDTH   = writeback_unit_pkg::SB_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_valid,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
    input  logic [1:0]                mem_wb_sel,
    input  logic [DATA_WIDTH-1:0]     mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     mem_read_data,
    input  logic [DATA_WIDTH-1:0]     mem_pc_plus4,
    input  logic                      issue_valid,
    input  logic                      issue_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] issue_reg,
    input  logic [REG_ADDR_WIDTH-1:0] read_reg_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_reg_2,
    output logic [REG_ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic                      reg_write,
    output logic [DATA_WIDTH-1:0]     fwd_data_1,
    output logic                      fwd_hit_1,
    output logic [DATA_WIDTH-1:0]     fwd_data_2,
    output logic                      fwd_hit_2,
    output logic                      busy_1,
    output logic                      busy_2,
    output logic                      sb_overflow
);
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO = REG_ADDR_WIDTH'(REG_ZERO);
    logic                  wb_valid, wb_reg_write, issue_inc;
    logic [DATA_WIDTH-1:0] mem_data;
    always_comb
        mem_data = mem_wb_sel == WB_SEL_ALU ? mem_alu_result :
                   mem_wb_sel == WB_SEL_MEM ? mem_read_data  :
                   mem_wb_sel == WB_SEL_PC4 ? mem_pc_plus4   : '0;
    // destination and data only move on a writing entry so they hold while reg_write is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_reg_write <= mem_reg_write;
            if (mem_valid && mem_reg_write) begin
                write_reg  <= mem_write_reg;
                write_data <= mem_data;
            end
        end
    end
    assign reg_write  = wb_valid & wb_reg_write & (write_reg != ZERO);
    assign fwd_hit_1  = reg_write & (read_reg_1 == write_reg);
    assign fwd_hit_2  = reg_write & (read_reg_2 == write_reg);
    assign fwd_data_1 = write_data;
    assign fwd_data_2 = write_data;
    assign issue_inc  = issue_valid & issue_reg_write & (issue_reg != ZERO);
    pending_write_scoreboard #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .SB_CNT_WIDTH  (SB_CNT_WIDTH)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .inc        (issue_inc),
        .inc_reg    (issue_reg),
        .dec        (reg_write),
        .dec_reg    (write_reg),
        .read_reg_1 (read_reg_1),
        .read_reg_2 (read_reg_2),
        .fwd_hit_1  (fwd_hit_1),
        .fwd_hit_2  (fwd_hit_2),
        .busy_1     (busy_1),
        .busy_2     (busy_2),
        .sb_overflow(sb_overflow)
    );
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scoreboard bench for writeback_unit
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0, mem_reg_write = 1'b0;
    logic [4:0]  mem_write_reg = '0;
    logic [1:0]  mem_wb_sel = '0;
    logic [31:0] mem_alu_result = '0, mem_read_data = '0, mem_pc_plus4 = '0;
    logic        issue_valid = 1'b0, issue_reg_write = 1'b0;
    logic [4:0]  issue_reg = '0, read_reg_1 = '0, read_reg_2 = '0;
    logic [4:0]  write_reg;
    logic [31:0] write_data, fwd_data_1, fwd_data_2;
    logic        reg_write, fwd_hit_1, fwd_hit_2, busy_1, busy_2, sb_overflow;
    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;
    wb_exp_t     q[$];
    logic [4:0]  h_reg = '0;
    logic [31:0] h_data = '0;
    int          n_assert = 0, n_fail = 0;
    writeback_unit dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg),
        .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
        .mem_pc_plus4(mem_pc_plus4), .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
        .issue_reg(issue_reg), .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .fwd_data_1(fwd_data_1), .fwd_hit_1(fwd_hit_1), .fwd_data_2(fwd_data_2), .fwd_hit_2(fwd_hit_2),
        .busy_1(busy_1), .busy_2(busy_2), .sb_overflow(sb_overflow)
    );
    always #5 clk = ~clk;
    task automatic chk1(string tag, logic obs, logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic mem_in(logic v, logic rw, logic [4:0] rd, logic [1:0] sel, logic [31:0] alu, logic [31:0] ld, logic [31:0] pc);
        wb_exp_t e;
        mem_valid = v; mem_reg_write = rw; mem_write_reg = rd; mem_wb_sel = sel;
        mem_alu_result = alu; mem_read_data = ld; mem_pc_plus4 = pc;
        if (v && rw) begin
            h_reg = rd;
            case (sel)
                2'd0:    h_data = alu;
                2'd1:    h_data = ld;
                2'd2:    h_data = pc;
                default: h_data = '0;
            endcase
        end
        e.rw = v && rw && rd != 5'd0;
        e.rd = h_reg;
        e.data = h_data;
        q.push_back(e);
    endtask
    task automatic idle();
        mem_in(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0);
    endtask
    task automatic issue(logic v, logic [4:0] rd);
        issue_valid = v; issue_reg_write = v; issue_reg = rd;
    endtask
    task automatic tick();
        wb_exp_t e;
        @(posedge clk);
        #1;
        n_assert++;
        assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL queue: observed empty expected entry");
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk1("reg_write", reg_write, e.rw);
            chk32("write_reg", {27'b0, write_reg}, {27'b0, e.rd});
            chk32("write_data", write_data, e.data);
        end
    endtask
    initial begin
        @(posedge clk);
        #1;
        chk1("rst reg_write", reg_write, 1'b0);
        chk32("rst write_data", write_data, 32'h0);
        chk1("rst busy_1", busy_1, 1'b0);
        chk1("rst ovf", sb_overflow, 1'b0);
        reset = 1'b0;
        read_reg_1 = 5'd3;
        mem_in(1'b1, 1'b1, 5'd3, 2'd1, 32'h11, 32'hDEADBEEF, 32'h4);
        tick();
        chk1("fwd_hit_1 r3", fwd_hit_1, 1'b1);
        chk32("fwd_data_1 r3", fwd_data_1, 32'hDEADBEEF);
        chk1("busy_1 r3 unissued", busy_1, 1'b0);
        read_reg_2 = 5'd31;
        mem_in(1'b1, 1'b1, 5'd31, 2'd2, 32'h22, 32'h33, 32'h00400008);
        tick();
        chk1("fwd_hit_2 r31", fwd_hit_2, 1'b1);
        chk1("fwd_hit_1 miss", fwd_hit_1, 1'b0);
        read_reg_1 = 5'd0;
        mem_in(1'b1, 1'b1, 5'd0, 2'd2, 32'h22, 32'h33, 32'h00400008);
        tick();
        chk1("fwd_hit_1 r0", fwd_hit_1, 1'b0);
        mem_in(1'b1, 1'b1, 5'd9, 2'd3, 32'h5, 32'h6, 32'h7);
        tick();
        read_reg_1 = 5'd5;
        issue(1'b1, 5'd5);
        idle();
        chk1("busy_1 r5 pre", busy_1, 1'b0);
        tick();
        issue(1'b0, 5'd0);
        chk1("busy_1 r5 issued", busy_1, 1'b1);
        mem_in(1'b1, 1'b1, 5'd5, 2'd0, 32'h55, 32'h0, 32'h0);
        tick();
        chk1("fwd_hit_1 r5", fwd_hit_1, 1'b1);
        chk1("busy_1 r5 fwd", busy_1, 1'b0);
        idle();
        tick();
        chk1("busy_1 r5 retired", busy_1, 1'b0);
        read_reg_2 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 5'd7);
            idle();
            tick();
            chk1("busy_2 r7 fill", busy_2, 1'b1);
            chk1("ovf fill", sb_overflow, 1'b0);
        end
        idle();
        tick();
        issue(1'b0, 5'd0);
        chk1("ovf set", sb_overflow, 1'b1);
        chk1("busy_2 r7 sat", busy_2, 1'b1);
        mem_in(1'b1, 1'b1, 5'd7, 2'd0, 32'h77, 32'h0, 32'h0);
        tick();
        chk1("fwd_hit_2 r7", fwd_hit_2, 1'b1);
        chk1("busy_2 r7 cnt3", busy_2, 1'b1);
        issue(1'b1, 5'd7);
        idle();
        tick();
        issue(1'b0, 5'd0);
        chk1("busy_2 inc+dec", busy_2, 1'b1);
        mem_in(1'b1, 1'b1, 5'd7, 2'd0, 32'h1, 32'h0, 32'h0);
        tick();
        chk1("busy_2 drain 3", busy_2, 1'b1);
        mem_in(1'b1, 1'b1, 5'd7, 2'd0, 32'h2, 32'h0, 32'h0);
        tick();
        chk1("busy_2 drain 2", busy_2, 1'b1);
        mem_in(1'b1, 1'b1, 5'd7, 2'd0, 32'h3, 32'h0, 32'h0);
        tick();
        chk1("busy_2 drain 1 fwd", busy_2, 1'b0);
        idle();
        tick();
        chk1("busy_2 drained", busy_2, 1'b0);
        chk1("ovf sticky", sb_overflow, 1'b1);
        mem_in(1'b1, 1'b1, 5'd2, 2'd0, 32'h1, 32'h0, 32'h0);
        tick();
        mem_in(1'b1, 1'b1, 5'd4, 2'd0, 32'h2, 32'h0, 32'h0);
        tick();
        issue(1'b1, 5'd7);
        mem_in(1'b1, 1'b1, 5'd6, 2'd0, 32'h66, 32'h0, 32'h0);
        tick();
        issue(1'b0, 5'd0);
        chk1("pre-reset busy_2", busy_2, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("mid rst reg_write", reg_write, 1'b0);
        chk32("mid rst write_data", write_data, 32'h0);
        chk1("mid rst busy_2", busy_2, 1'b0);
        chk1("mid rst ovf", sb_overflow, 1'b0);
        q.delete();
        h_reg = '0;
        h_data = '0;
        @(negedge clk);
        reset = 1'b0;
        idle();
        tick();
        chk1("post rst busy_2", busy_2, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
